// File: rtl/pc_mod.sv
// Program-counter register: load from pc_in, auto-increment or hold, with async active-low reset.
// Optional feature macro: PC_MOD_WRAP_FLAG_EN adds the registered pc_wrap flag.
module pc_mod #(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pwen,
   input  logic [WIDTH-1:0] pc_in,
   input  logic             pc_inc,
   output logic [WIDTH-1:0] pc_out,
   output logic [WIDTH-1:0] pc_plus1
`ifdef PC_MOD_WRAP_FLAG_EN
   ,
   output logic             pc_wrap
`endif
);

   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] w_pc_plus1;
   logic [WIDTH-1:0] w_pc_next;

   assign w_pc_plus1 = r_pc + WIDTH'(1);

   // Load has priority over increment; otherwise hold.
   always_comb begin
      w_pc_next = r_pc;
      if (pwen) begin
         w_pc_next = pc_in;
      end else if (pc_inc) begin
         w_pc_next = w_pc_plus1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc <= RESET_VAL;
      end else begin
         r_pc <= w_pc_next;
      end
   end

   assign pc_out   = r_pc;
   assign pc_plus1 = w_pc_plus1;

`ifdef PC_MOD_WRAP_FLAG_EN
   logic r_wrap;
   logic w_wrap_next;

   // Only an increment out of all-ones counts as a wrap; a load to 0 does not.
   assign w_wrap_next = !pwen && pc_inc && (r_pc == {WIDTH{1'b1}});

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wrap <= 1'b0;
      end else begin
         r_wrap <= w_wrap_next;
      end
   end

   assign pc_wrap = r_wrap;
`endif

endmodule

// File: tb/tb_pc_mod.sv
// Scoreboard bench for pc_mod: expected PC values are queued at stimulus time and
// popped after the following rising edge.
module tb_pc_mod;

   localparam int WIDTH = 4;

   typedef struct {
      logic [WIDTH-1:0] pc;
      logic [WIDTH-1:0] plus1;
      logic             wrap;
   } exp_t;

   logic             clk;
   logic             reset;
   logic             pwen;
   logic [WIDTH-1:0] pc_in;
   logic             pc_inc;
   logic [WIDTH-1:0] pc_out;
   logic [WIDTH-1:0] pc_plus1;
`ifdef PC_MOD_WRAP_FLAG_EN
   logic             pc_wrap;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   exp_t             sb_q[$];
   logic [WIDTH-1:0] m_pc;

   pc_mod #(.WIDTH(WIDTH), .RESET_VAL('0)) dut (
      .clk      (clk),
      .reset    (reset),
      .pwen     (pwen),
      .pc_in    (pc_in),
      .pc_inc   (pc_inc),
      .pc_out   (pc_out),
      .pc_plus1 (pc_plus1)
`ifdef PC_MOD_WRAP_FLAG_EN
      ,
      .pc_wrap  (pc_wrap)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_wrap(input string tag, input logic exp);
`ifdef PC_MOD_WRAP_FLAG_EN
      check_val(tag, {31'b0, pc_wrap}, {31'b0, exp});
`else
      if (exp) begin
         // flag not built; nothing to compare
      end
`endif
   endtask

   // Drive one cycle of stimulus at the falling edge, queue the model result,
   // then compare against the DUT just after the next rising edge.
   task automatic step(input logic w, input logic inc, input logic [WIDTH-1:0] din, input string tag);
      exp_t e;
      exp_t got;
      @(negedge clk);
      pwen   = w;
      pc_inc = inc;
      pc_in  = din;
      e.wrap = !w && inc && (m_pc == {WIDTH{1'b1}});
      if (w)        m_pc = din;
      else if (inc) m_pc = m_pc + WIDTH'(1);
      e.pc    = m_pc;
      e.plus1 = m_pc + WIDTH'(1);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         got = sb_q.pop_front();
         check_val({tag, "_pc"},    {28'b0, pc_out},   {28'b0, got.pc});
         check_val({tag, "_plus1"}, {28'b0, pc_plus1}, {28'b0, got.plus1});
         check_wrap({tag, "_wrap"}, got.wrap);
         $display("[TB] %s pwen=%0b inc=%0b in=%0d -> pc=%0d plus1=%0d", tag, w, inc, din, pc_out, pc_plus1);
      end
   endtask

   initial begin
      reset  = 1'b0;
      pwen   = 1'b0;
      pc_inc = 1'b0;
      pc_in  = 4'd7;
      m_pc   = '0;

      // Reset-low window with the clock running and a tempting pc_in.
      #1;
      check_val("rst_pc", {28'b0, pc_out}, 32'd0);
      check_val("rst_plus1", {28'b0, pc_plus1}, 32'd1);
      check_wrap("rst_wrap", 1'b0);
      pwen = 1'b1;
      pc_inc = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check_val("rst_hold_pc", {28'b0, pc_out}, 32'd0);
      end
      @(negedge clk);
      pwen = 1'b0;
      pc_inc = 1'b0;
      reset = 1'b1;
      step(1'b0, 1'b0, 4'd7, "idle_a");
      // Second reset-low window.
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         check_val("rst2_pc", {28'b0, pc_out}, 32'd0);
      end
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'd7, "hold0");
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'd7, "load7");

      step(1'b1, 1'b0, 4'd14, "load14");
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'd7, "inc");
      step(1'b0, 1'b0, 4'd7, "hold1");

      step(1'b1, 1'b1, 4'd3, "load_wins");
      step(1'b1, 1'b1, 4'd3, "load_wins2");

      // Load all-ones directly, then load 0: a load to 0 is not a wrap.
      step(1'b1, 1'b0, 4'd15, "load15");
      step(1'b1, 1'b1, 4'd0, "load0_nowrap");

      // Asynchronous reset between edges.
      step(1'b1, 1'b0, 4'd9, "load9");
      @(negedge clk);
      pwen = 1'b1;
      pc_in = 4'd5;
      #2;
      reset = 1'b0;
      #1;
      check_val("async_pc", {28'b0, pc_out}, 32'd0);
      check_val("async_plus1", {28'b0, pc_plus1}, 32'd1);
      check_wrap("async_wrap", 1'b0);
      @(posedge clk);
      #1;
      check_val("async_hold_pc", {28'b0, pc_out}, 32'd0);
      m_pc = '0;
      @(negedge clk);
      reset = 1'b1;
      step(1'b1, 1'b0, 4'd5, "reload5");

      // Random traffic against the model.
      for (int i = 0; i < 40; i++) begin
         step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), "rand");
      end

      check_val("sb_drained", sb_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
